// File: rtl/track_position_ctrl_if.sv
// Command handshake between a host and the track position controller.
// cmd_pos carries one bit more than a slot index so that out-of-range
// targets reach the controller intact and can be rejected, not aliased.
interface track_position_ctrl_if #(
  parameter int NUM_SLOTS = 16
);
  localparam int CW = $clog2(NUM_SLOTS) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_pos;

  modport master (output cmd_valid, output cmd_pos, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_pos, output cmd_ready);
endinterface

// File: rtl/track_position_ctrl.sv
// Track slot positioner: homes against a limit switch, then moves the
// carriage slot-by-slot to commanded targets with a settle period after
// every motion. Emergency stop latches a fault until a re-home request.
// Every output is a flop loaded from next-state values.
module track_position_ctrl #(
  parameter int TICKS_PER_SLOT = 2500000,
  parameter int NUM_SLOTS      = 16,
  parameter int SETTLE_CYCLES  = 500000,
  parameter int HOME_TIMEOUT   = 50000000,
  localparam int PW            = $clog2(NUM_SLOTS)
)(
  input  logic                  clk,
  input  logic                  rst_n,
  track_position_ctrl_if.slave  cmd,
  input  logic                  home_req,
  input  logic                  stop_i,
  input  logic                  home_sw,
  output logic                  move_o,
  output logic                  back_o,
  output logic [PW-1:0]         pos_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int CW    = PW + 1;
  localparam int MAX_A = (TICKS_PER_SLOT > SETTLE_CYCLES) ? TICKS_PER_SLOT : SETTLE_CYCLES;
  localparam int MAXC  = (HOME_TIMEOUT > MAX_A) ? HOME_TIMEOUT : MAX_A;
  localparam int CNTW  = $clog2(MAXC + 1);

  localparam logic [CNTW-1:0] TICK_LAST   = CNTW'(TICKS_PER_SLOT - 1);
  localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE_CYCLES - 1);
  localparam logic [CNTW-1:0] HOME_LAST   = CNTW'(HOME_TIMEOUT - 1);
  localparam logic [PW-1:0]   POS_MAX     = PW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0]   SLOTS_W     = CW'(NUM_SLOTS);

  typedef enum logic [2:0] {
    S_HOME, S_IDLE, S_FWD, S_BACK, S_SETTLE, S_FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [PW-1:0]   tgt_q, tgt_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            sw_m_q, sw_s_q;
  logic            move_q, back_q, busy_q, done_q, err_q, ready_q;
  logic            done_d, rej_d;
  logic            accept;
  logic [PW-1:0]   pos_step;

  assign accept = cmd.cmd_valid && ready_q;

  // Two-flop synchronizer for the asynchronous home limit switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m_q <= 1'b0;
      sw_s_q <= 1'b0;
    end else begin
      sw_m_q <= home_sw;
      sw_s_q <= sw_m_q;
    end
  end

  // State, position, target and the shared tick/settle/timeout counter.
  // Reset parks the FSM in HOME, so the first edge after release is
  // already a homing cycle; the output flops below stay quiet until then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HOME;
      pos_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The counter free-runs inside a state and is cleared
  // on every transition and at each slot boundary, which also discards
  // partial-slot ticks when a stop interrupts motion.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q + CNTW'(1);
    done_d   = 1'b0;
    rej_d    = 1'b0;
    pos_step = pos_q;
    unique case (state_q)
      S_HOME: begin
        if (stop_i) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (sw_s_q) begin
          pos_d   = '0;
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == HOME_LAST) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        // A handshake that completes wins over a coincident home_req.
        if (accept) begin
          if (cmd.cmd_pos >= SLOTS_W) begin
            rej_d = 1'b1;
          end else if (cmd.cmd_pos == {1'b0, pos_q}) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = cmd.cmd_pos[PW-1:0];
            state_d = (cmd.cmd_pos > {1'b0, pos_q}) ? S_FWD : S_BACK;
          end
        end else if (home_req) begin
          state_d = S_HOME;
        end
      end
      S_FWD: begin
        if (stop_i) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (cnt_q == TICK_LAST) begin
          cnt_d    = '0;
          pos_step = (pos_q == POS_MAX) ? pos_q : pos_q + PW'(1);
          pos_d    = pos_step;
          if (pos_step == tgt_q || pos_q == POS_MAX) state_d = S_SETTLE;
        end
      end
      S_BACK: begin
        if (stop_i) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (sw_s_q) begin
          // Hitting the home switch is the ground truth for slot 0.
          pos_d   = '0;
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == TICK_LAST) begin
          cnt_d    = '0;
          pos_step = (pos_q == '0) ? pos_q : pos_q - PW'(1);
          pos_d    = pos_step;
          if (pos_step == tgt_q || pos_q == '0) state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (stop_i) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_FAULT: begin
        cnt_d = '0;
        if (home_req && !stop_i) state_d = S_HOME;
      end
      default: begin
        state_d = S_FAULT;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs decoded from the next state so they change on the
  // same edge as the FSM. cmd_ready sees stop_i one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_q  <= 1'b0;
      back_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      move_q  <= (state_d == S_HOME) || (state_d == S_FWD) || (state_d == S_BACK);
      back_q  <= (state_d == S_HOME) || (state_d == S_BACK);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      err_q   <= (state_d == S_FAULT) || rej_d;
      ready_q <= (state_d == S_IDLE) && !stop_i;
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign move_o        = move_q;
  assign back_o        = back_q;
  assign pos_o         = pos_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_track_position_ctrl.sv
// Scenario bench for track_position_ctrl with small timing parameters.
// Expected completion positions are queued when a command or homing is
// started and popped when done_o is observed.
module tb_track_position_ctrl;
  localparam int TICKS  = 4;
  localparam int SLOTS  = 16;
  localparam int SETTLE = 3;
  localparam int HTO    = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       home_req = 1'b0, stop_i = 1'b0, home_sw = 1'b0;
  logic       move_o, back_o, busy_o, done_o, err_o;
  logic [3:0] pos_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  track_position_ctrl_if #(.NUM_SLOTS(SLOTS)) cmd_if();

  track_position_ctrl #(
    .TICKS_PER_SLOT(TICKS), .NUM_SLOTS(SLOTS),
    .SETTLE_CYCLES(SETTLE), .HOME_TIMEOUT(HTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd_if),
    .home_req(home_req), .stop_i(stop_i), .home_sw(home_sw),
    .move_o(move_o), .back_o(back_o), .pos_o(pos_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic send(input int p);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_if.cmd_ready) begin ok = 1'b1; break; end
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_pos   = 5'(p);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_ready: cmd_ready %0b, required 1", cmd_if.cmd_ready); end
  endtask

  // Waits (bounded) for done_o, then pops the expected position.
  task automatic wait_done(input string nm, input int max);
    bit ok = 1'b0;
    int e;
    for (int i = 0; i < max; i++) begin
      if (done_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done: done_o never seen in %0d cycles", nm, max); end
    else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      checks++;
      if (int'(pos_o) !== e) begin errors++; $display("FAIL %s_pos: pos_o %0d, required %0d", nm, pos_o, e); end
    end
  endtask

  task automatic home_pulse();
    home_sw = 1'b1;
    repeat (3) @(negedge clk);
    home_sw = 1'b0;
  endtask

  task automatic wait_pos(input int p, input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (int'(pos_o) == p) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL wait_pos: pos_o %0d, required %0d", pos_o, p); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({move_o, back_o, busy_o, done_o, err_o, cmd_if.cmd_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_outs: m/b/busy/done/err/rdy %b, required 000000",
        {move_o, back_o, busy_o, done_o, err_o, cmd_if.cmd_ready});
    end
    checks++;
    if (pos_o !== 4'd0) begin errors++; $display("FAIL reset_pos: pos_o %0d, required 0", pos_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_o, move_o, back_o, cmd_if.cmd_ready} !== 4'b1110) begin
      errors++; $display("FAIL reset_home: busy/move/back/rdy %b, required 1110",
        {busy_o, move_o, back_o, cmd_if.cmd_ready});
    end
  endtask

  task automatic test_home();
    repeat (19) @(negedge clk);
    exp_q.push_back(0);
    home_pulse();
    wait_done("home", 20);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL home_idle: rdy %b busy %b, required 1 0", cmd_if.cmd_ready, busy_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL home_done_pulse: done_o %b, required 0", done_o); end
  endtask

  task automatic test_same_pos();
    exp_q.push_back(0);
    send(0);
    checks++;
    if (move_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL same_nomove: move %b busy %b, required 0 0", move_o, busy_o);
    end
    wait_done("same", 1);
  endtask

  task automatic test_fwd();
    int mv = 0, last = 0, k, e;
    bit bad_dir = 1'b0;
    for (int i = 1; i <= 5; i++) exp_q.push_back(i);
    send(5);
    for (int i = 0; i < 40; i++) begin
      if (int'(pos_o) != last) begin
        last = int'(pos_o);
        k = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (last !== k || mv !== TICKS * k) begin
          errors++; $display("FAIL fwd_step: pos_o %0d after %0d drive cycles, required %0d after %0d",
            last, mv, k, TICKS * k);
        end
      end
      if (move_o) begin mv++; if (back_o) bad_dir = 1'b1; end
      if (done_o) break;
      @(negedge clk);
    end
    checks++;
    if (mv !== 5 * TICKS || bad_dir) begin
      errors++; $display("FAIL fwd_drive: move cycles %0d back_seen %b, required %0d 0", mv, bad_dir, 5 * TICKS);
    end
    exp_q.push_back(5);
    wait_done("fwd", 10);
  endtask

  task automatic test_back_home();
    exp_q.push_back(0);
    send(2);
    wait_pos(4, 10);
    checks++;
    if (move_o !== 1'b1 || back_o !== 1'b1) begin
      errors++; $display("FAIL back_dir: move %b back %b, required 1 1", move_o, back_o);
    end
    home_pulse();
    wait_done("back_home", 20);
  endtask

  task automatic test_reject();
    send(20);
    checks++;
    if (err_o !== 1'b1 || move_o !== 1'b0 || busy_o !== 1'b0 || pos_o !== 4'd0) begin
      errors++; $display("FAIL reject: err %b move %b busy %b pos %0d, required 1 0 0 0", err_o, move_o, busy_o, pos_o);
    end
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL reject_pulse: err_o %b, required 0", err_o); end
  endtask

  task automatic test_idle_stop();
    stop_i = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_ready !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      errors++; $display("FAIL idle_stop: rdy %b busy %b err %b, required 0 0 0", cmd_if.cmd_ready, busy_o, err_o);
    end
    stop_i = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_unstop: rdy %b, required 1", cmd_if.cmd_ready); end
  endtask

  task automatic test_stop();
    send(9);
    wait_pos(3, 20);
    stop_i = 1'b1;
    @(negedge clk);
    checks++;
    if (move_o !== 1'b0 || err_o !== 1'b1 || cmd_if.cmd_ready !== 1'b0 || pos_o !== 4'd3) begin
      errors++; $display("FAIL stop_fault: move %b err %b rdy %b pos %0d, required 0 1 0 3",
        move_o, err_o, cmd_if.cmd_ready, pos_o);
    end
    repeat (3) @(negedge clk);
    stop_i = 1'b0;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || pos_o !== 4'd3 || move_o !== 1'b0) begin
      errors++; $display("FAIL stop_hold: err %b pos %0d move %b, required 1 3 0", err_o, pos_o, move_o);
    end
    home_req = 1'b1;
    @(negedge clk);
    home_req = 1'b0;
    checks++;
    if ({busy_o, move_o, back_o, err_o} !== 4'b1110) begin
      errors++; $display("FAIL stop_rehome: busy/move/back/err %b, required 1110", {busy_o, move_o, back_o, err_o});
    end
    exp_q.push_back(0);
    home_pulse();
    wait_done("stop_recover", 20);
  endtask

  task automatic test_reset_mid_back();
    exp_q.push_back(4);
    send(4);
    wait_done("pre_back", 40);
    send(1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({move_o, back_o, busy_o, done_o, err_o, cmd_if.cmd_ready} !== 6'b0 || pos_o !== 4'd0) begin
      errors++; $display("FAIL rst_mid_back: m/b/busy/done/err/rdy %b pos %0d, required 000000 0",
        {move_o, back_o, busy_o, done_o, err_o, cmd_if.cmd_ready}, pos_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_o, move_o, back_o, done_o} !== 4'b1110) begin
      errors++; $display("FAIL rst_rehome: busy/move/back/done %b, required 1110", {busy_o, move_o, back_o, done_o});
    end
    exp_q.push_back(0);
    home_pulse();
    wait_done("rst_recover", 20);
  endtask

  task automatic test_timeout();
    int n = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (err_o) begin n = i; break; end
    end
    checks++;
    if (n !== HTO || move_o !== 1'b0) begin
      errors++; $display("FAIL home_timeout: err after %0d cycles move %b, required %0d 0", n, move_o, HTO);
    end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_pos   = '0;
    test_reset();
    test_home();
    test_same_pos();
    test_fwd();
    test_back_home();
    test_reject();
    test_idle_stop();
    test_stop();
    test_reset_mid_back();
    test_timeout();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_left: %0d entries, required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
